mod12_down_counter: RTL
=======================

MOD12_DOWN_COUNTER -- requirements
Module: mod12_down_counter

Interface
REQ-001 The block SHALL have parameter MODULUS, default 12, meaning the count range 0..MODULUS-1.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on step_in.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port step_in, input, 1 bit: asynchronous, already-debounced step request; each rising edge requests one decrement.
REQ-006 Port en, input, 1 bit: step enable, synchronous to clk.
REQ-007 Port load, input, 1 bit: synchronous load strobe.
REQ-008 Port load_val, input, 4 bits: value to load.
REQ-009 Port count, output, 4 bits: current count, registered.
REQ-010 Port zero, output, 1 bit: high while count == 0, decoded from the count register only.
REQ-011 Port borrow, output, 1 bit: registered one-cycle pulse on a wrap from 0 to MODULUS-1.
REQ-012 Port load_err, output, 1 bit: registered one-cycle pulse when an out-of-range load_val is clamped.

Function
REQ-013 step_in SHALL pass through SYNC_STAGES flops and then one history flop; step_pulse = last sync stage AND NOT history flop.
REQ-014 With SYNC_STAGES=2, a step_in rise set up before clk edge N SHALL change count at edge N+2.
REQ-015 A step_in level held high SHALL produce exactly one step_pulse.
REQ-016 When step_pulse=1, en=1 and load=0: count != 0 SHALL give count-1, and count == 0 SHALL give MODULUS-1.
REQ-017 borrow SHALL be 1 for exactly the cycle after the wrap edge and 0 otherwise.
REQ-018 When en=0, step_pulse SHALL be discarded, not queued, and count SHALL hold.
REQ-019 load=1 SHALL set count to load_val at the next edge regardless of en, with priority over a coincident step_pulse; that step SHALL be dropped.
REQ-020 A load with load_val >= MODULUS SHALL set count to MODULUS-1 and pulse load_err for one cycle.
REQ-021 A load SHALL never assert borrow.
REQ-022 With no load and no qualifying step, count SHALL hold.
REQ-023 count SHALL never hold a value >= MODULUS.

Reset
REQ-024 While reset=1, count SHALL be 0, zero 1, borrow 0 and load_err 0, and all synchronizer and history flops SHALL be 0, immediately and independent of clk.
REQ-025 Reset asserted mid-step SHALL cancel any in-flight step_pulse.
REQ-026 After reset deasserts, a step_in level that is already high SHALL be counted once, as a rising edge.

Structure
REQ-027 MODULUS default, the count width (4) and the reset count value SHALL live in shared package mod12_pkg.
REQ-028 The synchronizer plus rising-edge detector SHALL be one sub-module, step_edge_sync, with ports clk, reset, async_in and pulse_out.
REQ-029 Next-count, wrap and clamp logic SHALL be combinational in the top level, feeding a single registered state.

Verification
REQ-030 Reset, then 12 step_in rises with en=1 -> count 0,11,10,...,1,0; borrow pulses once, on the first step; zero high at start and end.
REQ-031 step_in rise before edge N -> count changes at edge N+2; step_in held high 20 cycles -> exactly one decrement.
REQ-032 en=0 with 3 step rises -> count unchanged; then en=1 with 1 step rise -> exactly one decrement.
REQ-033 load=1, load_val=7, coincident with step_pulse -> count=7, no decrement; load_val=14 -> count=11, load_err one-cycle pulse, no borrow.
REQ-034 Reset asserted between clk edges while a step is in flight, with count=5 -> count=0 immediately; no decrement after reset release unless a new edge is seen.

Source files
------------

// File: rtl/mod12_pkg.sv
// Shared constants for the modulo-12 down counter and its step synchronizer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mod12_pkg;

    // Default count range is 0..MODULUS_DEF-1
    localparam int MODULUS_DEF = 12;

    // Width of the count register and of load_val
    localparam int CNT_W = 4;

    // Count value forced while reset is high
    localparam logic [CNT_W-1:0] CNT_RST = '0;

endpackage

// File: rtl/step_edge_sync.sv
// Synchronizes an asynchronous step level into clk and emits one pulse per rising edge.
// Latency: a rise set up before edge N gives pulse_out high between edges N+SYNC_STAGES-1 and N+SYNC_STAGES.
// Backpressure: none; the pulse is one cycle wide and is not held for a consumer.
module step_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw level through the synchronizer chain and remember the last stage one cycle back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(async_in);
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Because history clears on reset, a level already high at release is seen as a fresh rise
    assign pulse_out = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/mod12_down_counter.sv
// Modulo-MODULUS down counter stepped by a synchronized async edge, with clamped synchronous load.
// Latency: count updates at edge N+1+SYNC_STAGES-1 after a step rise set up before edge N; load takes one edge.
// Backpressure: none; steps arriving while en=0 or during a load are dropped, never queued.
module mod12_down_counter
    import mod12_pkg::*;
#(
    parameter int MODULUS     = MODULUS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             borrow,
    output logic             load_err
);

    // Highest legal count; also the wrap target and the clamp value
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MODULUS - 1);

    logic             step_pulse;
    logic [CNT_W-1:0] count_nxt;
    logic             borrow_nxt;
    logic             load_err_nxt;

    step_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (step_in),
        .pulse_out (step_pulse)
    );

    // Load wins over a coincident step; out-of-range loads clamp to the top of the range
    always_comb begin
        count_nxt    = count;
        borrow_nxt   = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            if (load_val > MAX_CNT) begin
                count_nxt    = MAX_CNT;
                load_err_nxt = 1'b1;
            end else begin
                count_nxt = load_val;
            end
        end else if (step_pulse && en) begin
            if (count == '0) begin
                count_nxt  = MAX_CNT;
                borrow_nxt = 1'b1;
            end else begin
                count_nxt = count - CNT_W'(1);
            end
        end
    end

    // Single registered state: count plus the two one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= CNT_RST;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            borrow   <= borrow_nxt;
            load_err <= load_err_nxt;
        end
    end

    // Decoded from the register only so it never glitches on next-state logic
    assign zero = (count == '0);

endmodule
